// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM states, the canonical NOP and
// the base-ISA opcodes that the control unit decodes.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    BUF,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/riscv_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it while decode
// stalls, drop it once consumed or flushed. An empty slot always carries NOP.
module riscv_if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic            stall,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (!stall) begin
      // Decode took the instruction (or the slot was already empty).
      valid <= 1'b0;
      instr <= NOP;
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding req/gnt/rvalid
// fetch FSM with a one-entry skid buffer, and feeds the IF/ID register.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [6:0]      opcode_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [XLEN-1:0] buf_instr_q, buf_instr_d;

  logic            id_load, id_flush;
  logic [XLEN-1:0] id_load_pc, id_load_instr;
  logic            slot_free;
  logic [XLEN-1:0] redirect_target;

  assign slot_free       = !if_valid_o || !stall_i;
  assign redirect_target = redirect_pc_i & ~32'h3;
  assign imem_addr_o     = pc_q;
  assign opcode_o        = if_instr_o[6:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      // NOTE: the skid buffer is reset too; it is a single entry, so clearing
      // it costs nothing and keeps X out of the IF/ID path.
      buf_pc_q    <= '0;
      buf_instr_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    imem_req_o    = 1'b0;
    id_load       = 1'b0;
    id_flush      = 1'b0;
    id_load_pc    = pc_q;
    id_load_instr = imem_rdata_i;

    // Redirect wins over everything; the per-state code only picks the next state.
    if (redirect_i) begin
      pc_d = redirect_target;
      if (state_q != IDLE) begin
        id_flush    = 1'b1;
        buf_pc_d    = '0;
        buf_instr_d = NOP_INSTR;
      end
    end

    case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        imem_req_o = 1'b1;
        if (redirect_i)      state_d = imem_gnt_i ? DRAIN : REQ;
        else if (imem_gnt_i) state_d = WAIT;
      end

      WAIT: begin
        if (redirect_i) begin
          state_d = imem_rvalid_i ? REQ : DRAIN;
        end else if (imem_rvalid_i) begin
          pc_d = pc_q + 32'd4;
          if (slot_free) begin
            id_load = 1'b1;
            state_d = REQ;
          end else begin
            buf_pc_d    = pc_q;
            buf_instr_d = imem_rdata_i;
            state_d     = BUF;
          end
        end
      end

      BUF: begin
        if (redirect_i) begin
          state_d = REQ;
        end else if (!stall_i) begin
          id_load       = 1'b1;
          id_load_pc    = buf_pc_q;
          id_load_instr = buf_instr_q;
          buf_pc_d      = '0;
          buf_instr_d   = NOP_INSTR;
          state_d       = REQ;
        end
      end

      // The stale response is dropped whether or not a new redirect arrives.
      DRAIN: if (imem_rvalid_i) state_d = REQ;

      default: state_d = IDLE;
    endcase
  end

  riscv_if_id_reg #(
    .NOP(NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (id_flush),
    .load      (id_load),
    .stall     (stall_i),
    .load_pc   (id_load_pc),
    .load_instr(id_load_instr),
    .valid     (if_valid_o),
    .pc        (if_pc_o),
    .instr     (if_instr_o)
  );

endmodule
